cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer_pkg.sv | 55 +++++
 rtl/cpu_sequencer_retire_counter.sv | 30 +++
 rtl/cpu_sequencer.sv | 135 +++++++++++++
 tb/tb_cpu_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// cpu_sequencer_pkg
// Shared definitions for the multi-cycle CPU sequencer:
//   - op_code_e   : RV32I major opcodes (instruction[6:2]); this is the single
//                   definition of the encoding the decoder also uses.
//   - seq_state_e : sequencer FSM state encoding (visible on the debug port).
//   - helpers     : opcode legality and memory-class classification.
// ----------------------------------------------------------------------------
package cpu_sequencer_pkg;

   localparam int unsigned OPCODE_W  = 5;
   localparam int unsigned STATE_W   = 3;
   localparam int unsigned INSTRET_W = 32;

   // Major opcodes, instruction[6:2]
   typedef enum logic [OPCODE_W-1:0] {
      OP_LOAD   = 5'b00000,
      OP_OP_IMM = 5'b00100,
      OP_AUIPC  = 5'b00101,
      OP_STORE  = 5'b01000,
      OP_OP     = 5'b01100,
      OP_LUI    = 5'b01101,
      OP_BRANCH = 5'b11000,
      OP_JALR   = 5'b11001,
      OP_JAL    = 5'b11011
   } op_code_e;

   // Sequencer states; 6 and 7 are unused and recover to FETCH
   typedef enum logic [STATE_W-1:0] {
      S_FETCH   = 3'd0,
      S_DECODE  = 3'd1,
      S_EXECUTE = 3'd2,
      S_MEM     = 3'd3,
      S_WB      = 3'd4,
      S_TRAP    = 3'd5
   } seq_state_e;

   // True for the nine opcodes the core implements
   function automatic logic is_legal_op(input logic [OPCODE_W-1:0] op);
      logic legal;
      legal = 1'b0;
      case (op)
         OP_OP, OP_OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
         OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
         default:                           legal = 1'b0;
      endcase
      return legal;
   endfunction

   // True for instructions that need a data memory access
   function automatic logic is_mem_op(input logic [OPCODE_W-1:0] op);
      return (op == OP_LOAD) || (op == OP_STORE);
   endfunction

endpackage

// File: rtl/cpu_sequencer_retire_counter.sv
// ----------------------------------------------------------------------------
// retire_counter
// Free-running retired-instruction counter; wraps silently at all-ones.
// Ports:
//   clk   - clock
//   clr   - synchronous clear (highest priority)
//   inc   - add one on this edge
//   count - current count
// ----------------------------------------------------------------------------
module retire_counter
   import cpu_sequencer_pkg::*;
#(
   parameter int unsigned WIDTH = INSTRET_W
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   // Count register; natural modulo-2^WIDTH wrap
   always_ff @(posedge clk) begin
      if (clr) begin
         count <= '0;
      end else if (inc) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/cpu_sequencer.sv
// ----------------------------------------------------------------------------
// cpu_sequencer
// Multi-cycle control FSM: FETCH -> DECODE -> EXECUTE -> [MEM] -> WB.
// Strobes are decoded from the state register (and the ack inputs where a
// same-cycle handshake is needed), and are forced low while reset is high.
//
// Optional feature: define ILLEGAL_TRAP_EN to send illegal opcodes to a
// sticky TRAP state; otherwise they retire as NOPs and trap stays 0.
//
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   opcode          - instruction[6:2] from the instruction register
//   reg_we_dec      - decoder register-write request
//   imem_ack        - instruction memory data valid (honoured in FETCH only)
//   dmem_ack        - data memory access done (honoured in MEM only)
//   imem_req        - instruction fetch request
//   dmem_req/dmem_we- data memory request / write qualifier
//   ir_we           - instruction register load
//   rf_we           - register file write enable
//   pc_we           - PC update enable
//   state           - current FSM state (debug)
//   trap            - illegal-instruction trap flag (sticky until reset)
//   instret         - retired instruction count
// ----------------------------------------------------------------------------
module cpu_sequencer
   import cpu_sequencer_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  opcode,
   input  logic        reg_we_dec,
   input  logic        imem_ack,
   input  logic        dmem_ack,
   output logic        imem_req,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic        ir_we,
   output logic        rf_we,
   output logic        pc_we,
   output logic [2:0]  state,
   output logic        trap,
   output logic [31:0] instret
);

   seq_state_e state_q;
   seq_state_e state_d;
   logic       retire;
   logic       op_legal;

   assign op_legal = is_legal_op(opcode);
   assign state    = STATE_W'(state_q);

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and strobe decode; reset masks every strobe and ack
   always_comb begin
      state_d  = state_q;
      imem_req = 1'b0;
      ir_we    = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      rf_we    = 1'b0;
      pc_we    = 1'b0;
      retire   = 1'b0;
      if (!reset) begin
         case (state_q)
            S_FETCH: begin
               imem_req = 1'b1;
               if (imem_ack) begin
                  ir_we   = 1'b1;
                  state_d = S_DECODE;
               end
            end
            S_DECODE: begin
`ifdef ILLEGAL_TRAP_EN
               state_d = op_legal ? S_EXECUTE : S_TRAP;
`else
               state_d = S_EXECUTE;
`endif
            end
            S_EXECUTE: begin
               state_d = is_mem_op(opcode) ? S_MEM : S_WB;
            end
            S_MEM: begin
               dmem_req = 1'b1;
               dmem_we  = (opcode == OP_STORE);
               if (dmem_ack) begin
                  state_d = S_WB;
               end
            end
            S_WB: begin
               // Illegal opcodes only get here as NOPs: never write the RF
               rf_we   = reg_we_dec & op_legal;
               pc_we   = 1'b1;
               retire  = 1'b1;
               state_d = S_FETCH;
            end
            S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
               state_d = S_TRAP;
`else
               state_d = S_FETCH;
`endif
            end
            default: begin
               state_d = S_FETCH;
            end
         endcase
      end
   end

`ifdef ILLEGAL_TRAP_EN
   // TRAP is only left through reset, so the flag follows the state
   assign trap = (state_q == S_TRAP);
`else
   assign trap = 1'b0;
`endif

   retire_counter #(
      .WIDTH (INSTRET_W)
   ) u_retire_counter (
      .clk   (clk),
      .clr   (reset),
      .inc   (retire),
      .count (instret)
   );

endmodule

// File: tb/tb_cpu_sequencer.sv
// ----------------------------------------------------------------------------
// tb_cpu_sequencer
// Directed self-checking bench for cpu_sequencer. Inputs change 1 time unit
// after the rising edge; outputs are checked 1 unit after that, well before
// the next rising edge.
// ----------------------------------------------------------------------------
module tb_cpu_sequencer;

   logic        clk;
   logic        reset;
   logic [4:0]  opcode;
   logic        reg_we_dec;
   logic        imem_ack;
   logic        dmem_ack;
   logic        imem_req;
   logic        dmem_req;
   logic        dmem_we;
   logic        ir_we;
   logic        rf_we;
   logic        pc_we;
   logic [2:0]  state;
   logic        trap;
   logic [31:0] instret;

   int unsigned total;
   int unsigned bad;
   logic [31:0] instr;

   cpu_sequencer dut (
      .clk        (clk),
      .reset      (reset),
      .opcode     (opcode),
      .reg_we_dec (reg_we_dec),
      .imem_ack   (imem_ack),
      .dmem_ack   (dmem_ack),
      .imem_req   (imem_req),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .ir_we      (ir_we),
      .rf_we      (rf_we),
      .pc_we      (pc_we),
      .state      (state),
      .trap       (trap),
      .instret    (instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Packs strobes as {imem_req,ir_we,dmem_req,dmem_we,rf_we,pc_we}
   function automatic logic [31:0] strobes();
      return {26'd0, imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we};
   endfunction

   // Advance to 1 unit after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      reset      = 1'b1;
      opcode     = 5'd0;
      reg_we_dec = 1'b0;
      imem_ack   = 1'b1;   // acks during reset must be ignored
      dmem_ack   = 1'b1;
      instr      = 32'd0;

      tick();
      tick();
      #1;
      check("reset_strobes", strobes(), 32'h00);
      check("reset_state", 32'(state), 32'd0);
      check("reset_trap", 32'(trap), 32'd0);
      check("reset_instret", instret, 32'd0);

      // ---------------- ADDI x1,x0,5 -----------------------------------
      instr = 32'h00500093;
      tick();
      reset = 1'b0; opcode = instr[6:2]; reg_we_dec = 1'b1;
      imem_ack = 1'b1; dmem_ack = 1'b1;
      #1;
      check("addi_c1_state", 32'(state), 32'd0);
      check("addi_c1_strobes", strobes(), 32'h30);   // imem_req, ir_we
      tick(); #1;
      check("addi_c2_state", 32'(state), 32'd1);
      check("addi_c2_strobes", strobes(), 32'h00);   // ignores imem_ack
      tick(); #1;
      check("addi_c3_state", 32'(state), 32'd2);
      check("addi_c3_strobes", strobes(), 32'h00);
      tick();
      imem_ack = 1'b0; dmem_ack = 1'b0;
      #1;
      check("addi_c4_state", 32'(state), 32'd4);
      check("addi_c4_strobes", strobes(), 32'h03);   // rf_we, pc_we
      check("addi_c4_instret", instret, 32'd0);
      tick(); #1;
      check("addi_done_state", 32'(state), 32'd0);
      check("addi_done_instret", instret, 32'd1);
      check("fetch_wait_strobes", strobes(), 32'h20);
      tick(); #1;
      check("fetch_wait_state", 32'(state), 32'd0);

      // ---------------- LW x2,0(x1), ack on 4th MEM cycle --------------
      instr = 32'h0000A103;
      opcode = instr[6:2]; reg_we_dec = 1'b1; imem_ack = 1'b1;
      #1;
      check("lw_fetch_strobes", strobes(), 32'h30);
      tick(); imem_ack = 1'b0; #1;
      check("lw_decode_state", 32'(state), 32'd1);
      tick(); #1;
      check("lw_exec_state", 32'(state), 32'd2);
      for (int i = 1; i <= 4; i++) begin
         tick();
         dmem_ack = (i == 4);
         #1;
         check($sformatf("lw_mem%0d_state", i), 32'(state), 32'd3);
         check($sformatf("lw_mem%0d_strobes", i), strobes(), 32'h08);
      end
      tick(); dmem_ack = 1'b0; #1;
      check("lw_wb_state", 32'(state), 32'd4);
      check("lw_wb_strobes", strobes(), 32'h03);
      tick(); #1;
      check("lw_done_state", 32'(state), 32'd0);
      check("lw_done_instret", instret, 32'd2);

      // ---------------- SW x2,0(x1), immediate dmem_ack ----------------
      instr = 32'h0020A023;
      opcode = instr[6:2]; reg_we_dec = 1'b0; imem_ack = 1'b1;
      tick(); imem_ack = 1'b0; #1;
      check("sw_decode_state", 32'(state), 32'd1);
      tick(); #1;
      check("sw_exec_state", 32'(state), 32'd2);
      tick(); dmem_ack = 1'b1; #1;
      check("sw_mem_state", 32'(state), 32'd3);
      check("sw_mem_strobes", strobes(), 32'h0C);    // dmem_req, dmem_we
      tick(); dmem_ack = 1'b0; #1;
      check("sw_wb_state", 32'(state), 32'd4);
      check("sw_wb_strobes", strobes(), 32'h01);     // pc_we only
      tick(); #1;
      check("sw_done_instret", instret, 32'd3);

      // ---------------- Illegal opcode 0xFFFFFFFF ----------------------
      instr = 32'hFFFFFFFF;
      opcode = instr[6:2]; reg_we_dec = 1'b1; imem_ack = 1'b1;
      tick(); imem_ack = 1'b0; #1;
      check("ill_decode_state", 32'(state), 32'd1);
`ifdef ILLEGAL_TRAP_EN
      imem_ack = 1'b1; dmem_ack = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick(); #1;
         check($sformatf("trap%0d_state", i), 32'(state), 32'd5);
         check($sformatf("trap%0d_flag", i), 32'(trap), 32'd1);
         check($sformatf("trap%0d_strobes", i), strobes(), 32'h00);
      end
      check("trap_instret", instret, 32'd3);
      tick(); reset = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; #1;
      tick(); reset = 1'b0; #1;
      check("trap_clr_state", 32'(state), 32'd0);
      check("trap_clr_flag", 32'(trap), 32'd0);
      check("trap_clr_instret", instret, 32'd0);
`else
      tick(); #1;
      check("ill_exec_state", 32'(state), 32'd2);
      tick(); #1;
      check("ill_wb_state", 32'(state), 32'd4);
      check("ill_wb_strobes", strobes(), 32'h01);    // NOP: no rf_we
      check("ill_wb_trap", 32'(trap), 32'd0);
      tick(); #1;
      check("ill_done_state", 32'(state), 32'd0);
      check("ill_done_instret", instret, 32'd4);
`endif

      // ---------------- Reset during MEM with dmem_ack=1 ---------------
      instr = 32'h0000A103;
      opcode = instr[6:2]; reg_we_dec = 1'b1; imem_ack = 1'b1;
      tick(); imem_ack = 1'b0; #1;
      tick(); #1;
      tick(); #1;
      check("rst_mem_state", 32'(state), 32'd3);
      tick(); reset = 1'b1; dmem_ack = 1'b1; #1;
      check("rst_mem_strobes", strobes(), 32'h00);
      tick(); reset = 1'b0; dmem_ack = 1'b0; #1;
      check("rst_after_state", 32'(state), 32'd0);
      check("rst_after_instret", instret, 32'd0);
      check("rst_after_strobes", strobes(), 32'h20);  // imem_req at once
      tick(); #1;
      check("rst_hold_state", 32'(state), 32'd0);
      check("rst_hold_instret", instret, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
